transaction_control: RTL

//  Sequences one coin transfer between player 1 and player 2 balances in the single-port balance RAM.

---
 rtl/transaction_control.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/transaction_control.sv
// transaction_control: moves one coin amount between the two player balances
// held in a single-port RAM (address 0 = player 1, address 1 = player 2).
// Reads both balances, rejects on insufficient funds or destination overflow,
// writes both back, then hands off to the animation block.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start_transaction; RAM free for the display reader
// RD_SRC   | addressing source balance until read data has settled
// RD_DST   | addressing destination balance until read data has settled
// CHECK    | funds / overflow decision
// WR_SRC   | write debited source balance
// WR_DST   | write credited destination balance
// ANIM     | animation running; wait for anim_done or timeout
// DONE     | one-cycle completion pulse
// WAIT_REL | request still held after completion; wait for it to drop
module transaction_control #(
  parameter int BAL_W        = 8,
  parameter int AMT_W        = 8,
  parameter int RD_LAT       = 1,
  parameter int ANIM_TIMEOUT = 0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start_transaction,
  input  logic [AMT_W-1:0] amount,
  input  logic             key,
  input  logic [BAL_W-1:0] mem_rdata,
  input  logic             anim_done,
  output logic             mem_addr,
  output logic             mem_we,
  output logic [BAL_W-1:0] mem_wdata,
  output logic             mem_busy,
  output logic             anim_start,
  output logic             finished_transaction,
  output logic             tx_ok,
  output logic             tx_fail
);

  // One down-counter serves both the read settle time and the animation timeout.
  localparam int CNT_MAX = (ANIM_TIMEOUT > RD_LAT) ? ANIM_TIMEOUT : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SRC, S_RD_DST, S_CHECK, S_WR_SRC, S_WR_DST, S_ANIM, S_DONE, S_WAIT_REL
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic               key_q, key_d;
  logic [BAL_W-1:0]   src_bal_q, src_bal_d;
  logic [BAL_W-1:0]   dst_bal_q, dst_bal_d;
  logic               tx_ok_q, tx_ok_d;
  logic               tx_fail_q, tx_fail_d;
  logic               anim_first_q, anim_first_d;

  logic [BAL_W-1:0]   amt_ext;
  logic [BAL_W:0]     dst_sum;

  assign amt_ext = BAL_W'(amt_q);
  // One extra bit so an overflowing credit is detectable.
  assign dst_sum = {1'b0, dst_bal_q} + {1'b0, amt_ext};

  // State register and datapath latches, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      amt_q        <= '0;
      key_q        <= 1'b0;
      src_bal_q    <= '0;
      dst_bal_q    <= '0;
      tx_ok_q      <= 1'b0;
      tx_fail_q    <= 1'b0;
      anim_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      amt_q        <= amt_d;
      key_q        <= key_d;
      src_bal_q    <= src_bal_d;
      dst_bal_q    <= dst_bal_d;
      tx_ok_q      <= tx_ok_d;
      tx_fail_q    <= tx_fail_d;
      anim_first_q <= anim_first_d;
    end
  end

  // Next-state logic and state-decoded RAM / handshake outputs.
  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    amt_d                = amt_q;
    key_d                = key_q;
    src_bal_d            = src_bal_q;
    dst_bal_d            = dst_bal_q;
    tx_ok_d              = tx_ok_q;
    tx_fail_d            = tx_fail_q;
    anim_first_d         = (state_q == S_WR_DST);
    mem_addr             = 1'b0;
    mem_we               = 1'b0;
    mem_wdata            = '0;
    anim_start           = 1'b0;
    finished_transaction = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_transaction) begin
          state_d   = S_RD_SRC;
          amt_d     = amount;
          key_d     = key;
          tx_ok_d   = 1'b0;
          tx_fail_d = 1'b0;
          cnt_d     = CNT_W'(RD_LAT);
        end
      end
      S_RD_SRC: begin
        mem_addr = key_q;
        if (cnt_q == '0) begin
          src_bal_d = mem_rdata;
          cnt_d     = CNT_W'(RD_LAT);
          state_d   = S_RD_DST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RD_DST: begin
        mem_addr = ~key_q;
        if (cnt_q == '0) begin
          dst_bal_d = mem_rdata;
          state_d   = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CHECK: begin
        if ((amt_ext > src_bal_q) || dst_sum[BAL_W]) begin
          tx_fail_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_WR_SRC;
        end
      end
      S_WR_SRC: begin
        mem_we    = 1'b1;
        mem_addr  = key_q;
        mem_wdata = src_bal_q - amt_ext;
        state_d   = S_WR_DST;
      end
      S_WR_DST: begin
        mem_we    = 1'b1;
        mem_addr  = ~key_q;
        mem_wdata = dst_sum[BAL_W-1:0];
        tx_ok_d   = 1'b1;
        state_d   = S_ANIM;
        if (ANIM_TIMEOUT != 0) cnt_d = CNT_W'(ANIM_TIMEOUT - 1);
      end
      S_ANIM: begin
        anim_start = anim_first_q;
        if (anim_done) begin
          state_d = S_DONE;
        end else if ((ANIM_TIMEOUT != 0) && (cnt_q == '0)) begin
          state_d = S_DONE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        finished_transaction = 1'b1;
        state_d = start_transaction ? S_WAIT_REL : S_IDLE;
      end
      S_WAIT_REL: begin
        if (!start_transaction) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    mem_busy = (state_q != S_IDLE);
    tx_ok    = tx_ok_q;
    tx_fail  = tx_fail_q;
  end

endmodule
